// File: rtl/switch_egress_fifo.sv
// switch_egress_fifo
//   Per-output-port buffering stage directly behind the crossbar. Each switch
//   output feeds its own FIFO. The switch cannot be stalled, so beats that
//   arrive at a full FIFO are dropped and counted. Each FIFO is drained by its
//   egress consumer over a valid/ready handshake.
//
// Ports (p = 0..PORT_QTY-1, per-port fields packed at p*W +: W)
//   clk, reset     : clock, synchronous active-high reset
//   in_valid/data  : beat from switch output p (no backpressure)
//   out_valid/data : head of FIFO p (registered, no fall-through)
//   out_ready      : consumer p takes the head this cycle
//   full           : FIFO p holds DEPTH entries
//   fill_level     : entry count of FIFO p, 0..DEPTH
//   drop_count     : saturating count of beats dropped at port p
//   drop_clear     : pulse that clears drop_count[p]

// One port's FIFO, occupancy and drop counter.
module switch_egress_fifo_lane #(
   parameter int DATA_WIDTH     = 64,
   parameter int DEPTH          = 16,
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic [DATA_WIDTH-1:0]       in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic                        full,
   output logic [$clog2(DEPTH):0]      fill_level,
   output logic [DROP_CNT_WIDTH-1:0]   drop_count,
   input  logic                        drop_clear
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]          fill_q, fill_d;
   logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
   logic                      pop, push, drop;

   // Outputs depend only on registered state.
   assign out_valid  = (fill_q != '0);
   assign out_data   = mem_q[rd_ptr_q];
   assign full       = (fill_q == CNT_W'(DEPTH));
   assign fill_level = fill_q;
   assign drop_count = drop_q;

   always_comb begin
      pop  = out_valid && out_ready;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push = in_valid && (!full || pop);
      drop = in_valid && full && !pop;

      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop)
         rd_ptr_d = rd_ptr_q + PTR_W'(1);

      fill_d = fill_q + CNT_W'(push) - CNT_W'(pop);

      // A drop coinciding with a clear restarts the count at 1 so it is not lost.
      drop_d = drop_q;
      if (drop_clear)
         drop_d = drop ? DROP_CNT_WIDTH'(1) : '0;
      else if (drop && (drop_q != '1))
         drop_d = drop_q + DROP_CNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         fill_q   <= '0;
         drop_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
         drop_q   <= drop_d;
      end
   end

   // Storage is not reset; pointers and fill level define what is live.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

module switch_egress_fifo #(
   parameter int DATA_WIDTH     = 64,
   parameter int PORT_QTY       = 8,
   parameter int DEPTH          = 16,
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [PORT_QTY-1:0]                    in_valid,
   input  logic [PORT_QTY*DATA_WIDTH-1:0]         in_data,
   output logic [PORT_QTY-1:0]                    out_valid,
   input  logic [PORT_QTY-1:0]                    out_ready,
   output logic [PORT_QTY*DATA_WIDTH-1:0]         out_data,
   output logic [PORT_QTY-1:0]                    full,
   output logic [PORT_QTY*($clog2(DEPTH)+1)-1:0]  fill_level,
   output logic [PORT_QTY*DROP_CNT_WIDTH-1:0]     drop_count,
   input  logic [PORT_QTY-1:0]                    drop_clear
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   for (genvar p = 0; p < PORT_QTY; p++) begin : g_lane
      switch_egress_fifo_lane #(
         .DATA_WIDTH     (DATA_WIDTH),
         .DEPTH          (DEPTH),
         .DROP_CNT_WIDTH (DROP_CNT_WIDTH)
      ) u_lane (
         .clk        (clk),
         .reset      (reset),
         .in_valid   (in_valid[p]),
         .in_data    (in_data[p*DATA_WIDTH +: DATA_WIDTH]),
         .out_valid  (out_valid[p]),
         .out_ready  (out_ready[p]),
         .out_data   (out_data[p*DATA_WIDTH +: DATA_WIDTH]),
         .full       (full[p]),
         .fill_level (fill_level[p*CNT_W +: CNT_W]),
         .drop_count (drop_count[p*DROP_CNT_WIDTH +: DROP_CNT_WIDTH]),
         .drop_clear (drop_clear[p])
      );
   end
endmodule

// File: tb/tb_switch_egress_fifo.sv
module tb_switch_egress_fifo;
   localparam int DW = 64;
   localparam int NP = 8;
   localparam int DEPTH = 16;
   localparam int DCW = 4;
   localparam int FW = $clog2(DEPTH) + 1;

   logic               clk = 1'b0;
   logic               reset;
   logic [NP-1:0]      in_valid, out_valid, out_ready, full, drop_clear;
   logic [NP*DW-1:0]   in_data, out_data;
   logic [NP*FW-1:0]   fill_level;
   logic [NP*DCW-1:0]  drop_count;

   int total = 0;
   int bad   = 0;

   switch_egress_fifo #(
      .DATA_WIDTH(DW), .PORT_QTY(NP), .DEPTH(DEPTH), .DROP_CNT_WIDTH(DCW)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .full(full), .fill_level(fill_level),
      .drop_count(drop_count), .drop_clear(drop_clear)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] dout(int p);
      return out_data[p*DW +: DW];
   endfunction
   function automatic logic [FW-1:0] fill(int p);
      return fill_level[p*FW +: FW];
   endfunction
   function automatic logic [DCW-1:0] drops(int p);
      return drop_count[p*DCW +: DCW];
   endfunction

   task automatic drive(int p, logic v, logic [DW-1:0] d);
      in_valid[p]          = v;
      in_data[p*DW +: DW]  = d;
   endtask

   initial begin
      logic [DW-1:0] q[$];
      int            ndrop;
      logic          rdy, pop_m;

      reset = 1'b1; in_valid = '0; in_data = '0; out_ready = '0; drop_clear = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_valid", 64'(out_valid), 64'h0);
      chk("rst_fill",  64'(fill_level), 64'h0);
      chk("rst_full",  64'(full), 64'h0);
      chk("rst_drop",  64'(drop_count), 64'h0);

      // Port 3: latency and ordering
      for (int i = 0; i < 3; i++) begin
         drive(3, 1'b1, 64'hA0 + 64'(i));
         tick();
         if (i == 0) begin
            chk("p3_lat_valid", 64'(out_valid[3]), 64'h1);
            chk("p3_lat_data",  dout(3), 64'hA0);
         end
      end
      drive(3, 1'b0, '0);
      chk("p3_fill3", 64'(fill(3)), 64'd3);
      chk("p3_others_idle", 64'(out_valid & 8'hF7), 64'h0);
      out_ready[3] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("p3_drain_valid", 64'(out_valid[3]), 64'h1);
         chk("p3_drain_data",  dout(3), 64'hA0 + 64'(i));
         tick();
      end
      chk("p3_empty", 64'(out_valid[3]), 64'h0);
      out_ready[3] = 1'b0;

      // Port 0: fill and overflow
      for (int i = 0; i < 20; i++) begin
         drive(0, 1'b1, 64'(i));
         tick();
         if (i == 14) chk("p0_not_full15", 64'(full[0]), 64'h0);
         if (i == 15) chk("p0_full16",     64'(full[0]), 64'h1);
      end
      drive(0, 1'b0, '0);
      chk("p0_drop4", 64'(drops(0)), 64'd4);
      chk("p0_fill16", 64'(fill(0)), 64'd16);

      // Port 0 full: simultaneous push and pop
      chk("p0_head0", dout(0), 64'd0);
      out_ready[0] = 1'b1;
      drive(0, 1'b1, 64'h55);
      tick();
      drive(0, 1'b0, '0);
      out_ready[0] = 1'b0;
      chk("p0_pp_fill", 64'(fill(0)), 64'd16);
      chk("p0_pp_drop", 64'(drops(0)), 64'd4);
      out_ready[0] = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         chk("p0_drain", dout(0), (i == 16) ? 64'h55 : 64'(i));
         tick();
      end
      chk("p0_drained", 64'(out_valid[0]), 64'h0);
      out_ready[0] = 1'b0;

      // Port 5: pointer wrap with ready toggling every other cycle
      ndrop = 0;
      for (int i = 0; i < 40; i++) begin
         rdy   = 1'(i & 1);
         pop_m = rdy && (q.size() != 0);
         out_ready[5] = rdy;
         drive(5, 1'b1, 64'h100 + 64'(i));
         if (pop_m) begin
            chk("p5_wrap_data", dout(5), q[0]);
            void'(q.pop_front());
         end
         if (q.size() < DEPTH) q.push_back(64'h100 + 64'(i));
         else ndrop++;
         tick();
         chk("p5_wrap_fill", 64'(fill(5)), 64'(q.size()));
      end
      drive(5, 1'b0, '0);
      out_ready[5] = 1'b0;
      chk("p5_wrap_drops", 64'(drops(5)), 64'd4);
      out_ready[5] = 1'b1;
      while (q.size() != 0) begin
         chk("p5_tail_data", dout(5), q[0]);
         void'(q.pop_front());
         tick();
      end
      chk("p5_empty", 64'(out_valid[5]), 64'h0);
      out_ready[5] = 1'b0;

      // Port 1: drop counter saturation and clear
      for (int i = 0; i < 36; i++) begin
         drive(1, 1'b1, 64'(i));
         tick();
      end
      chk("p1_sat15", 64'(drops(1)), 64'd15);
      drop_clear[1] = 1'b1;
      tick();
      drop_clear[1] = 1'b0;
      chk("p1_clear_with_drop", 64'(drops(1)), 64'd1);
      drive(1, 1'b0, '0);
      drop_clear[1] = 1'b1;
      tick();
      drop_clear[1] = 1'b0;
      chk("p1_clear", 64'(drops(1)), 64'd0);

      // Reset mid-operation with data buffered; in_valid ignored during reset
      drive(2, 1'b1, 64'h77);
      tick();
      chk("pre_rst_valid", 64'(out_valid), 64'h06);
      reset    = 1'b1;
      in_valid = '1;
      tick();
      reset    = 1'b0;
      in_valid = '0;
      chk("mid_rst_valid", 64'(out_valid), 64'h0);
      chk("mid_rst_fill",  64'(fill_level), 64'h0);
      chk("mid_rst_full",  64'(full), 64'h0);
      tick();
      chk("post_rst_valid", 64'(out_valid), 64'h0);
      chk("post_rst_drop",  64'(drop_count), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/switch_egress_fifo.md
Name: switch_egress_fifo

Overview:
- Per-output-port buffering stage directly downstream of the crossbar switch.
- Captures each switch output beat (valid + data, no backpressure available from the switch) into an independent FIFO per output port.
- Presents each FIFO to its egress consumer over a valid/ready handshake.
- Beats arriving at a full FIFO are dropped and counted, so egress loss is observable.

Parameters:
- DATA_WIDTH, 64: width of one beat.
- PORT_QTY, 8: number of output ports, each with one independent FIFO.
- DEPTH, 16: entries per FIFO; power of two, >= 2.
- DROP_CNT_WIDTH, 16: width of each per-port saturating drop counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  PORT_QTY  beat present from switch output p this cycle
- in_data  input  PORT_QTY*DATA_WIDTH  switch output data; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH]
- out_valid  output  PORT_QTY  FIFO p head entry is valid
- out_ready  input  PORT_QTY  egress consumer p accepts the head this cycle
- out_data  output  PORT_QTY*DATA_WIDTH  head entry of FIFO p, same packing as in_data
- full  output  PORT_QTY  FIFO p holds DEPTH entries
- fill_level  output  PORT_QTY*($clog2(DEPTH)+1)  entry count of FIFO p, 0..DEPTH
- drop_count  output  PORT_QTY*DROP_CNT_WIDTH  beats dropped at port p
- drop_clear  input  PORT_QTY  one-cycle pulse that clears drop_count[p]

Behaviour:
- Reset (synchronous, active-high, on clk): all read/write pointers = 0, fill_level = 0, out_valid = 0, full = 0, drop_count = 0. out_data is don't-care while out_valid = 0. Storage contents are not reset.
- Reset mid-operation: all buffered beats are discarded. in_valid is ignored in the reset cycle. Normal operation resumes the cycle after reset deasserts.
- Ports are fully independent. No state is shared across p.
- Pop: occurs when out_valid[p] && out_ready[p]. rd_ptr advances modulo DEPTH.
- out_ready while out_valid = 0 has no effect.
- out_valid[p] = (fill_level[p] != 0). out_data[p] = storage at rd_ptr. Both are derived from registered state only, with no combinational path from in_* or out_ready.
- Push: occurs when in_valid[p] && (!full[p] || pop[p]). Data is written at wr_ptr, and wr_ptr advances modulo DEPTH.
- Latency: a beat written in cycle N is visible on out_valid/out_data in cycle N+1. There is no fall-through.
- Ordering: strict FIFO per port.
- fill_level update: next = fill_level + push - pop.
- full = (fill_level == DEPTH). Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is determined from fill_level, not from pointer comparison.
- Simultaneous push and pop when full: the push is accepted, and fill_level stays at DEPTH.
- Simultaneous push and pop when empty: impossible, because out_valid = 0.
- Simultaneous push and pop at intermediate levels: fill_level is unchanged.
- Drop: occurs when in_valid[p] && full[p] && !pop[p]. The beat is discarded, and drop_count[p] increments.
- drop_count saturates at 2^DROP_CNT_WIDTH-1 and never wraps.
- drop_clear[p] with no drop in the same cycle: drop_count[p] becomes 0 next cycle.
- drop_clear[p] with a drop in the same cycle: drop_count[p] becomes 1, so the event is not lost.
- Upstream contract: the switch never stalls. Loss is visible only through drop_count.

Test Plan:
- Reset/idle: hold reset 2 cycles, then release with no traffic -> all out_valid = 0, fill_level = 0, full = 0, drop_count = 0.
- Latency/order, port 3: push 0xA0, 0xA1, 0xA2 on consecutive cycles with out_ready[3] = 0 -> out_valid[3] rises the cycle after the first push, fill_level[3] = 3. Then set out_ready[3] = 1 -> 0xA0, 0xA1, 0xA2 appear on consecutive cycles, then out_valid[3] = 0. Other ports are untouched.
- Fill/overflow, port 0, DEPTH = 16, out_ready = 0: push 20 beats, values 0..19 -> full[0] = 1 after the 16th push, drop_count[0] = 4, and draining yields 0..15 only.
- Full with simultaneous push/pop: port 0 full, out_ready[0] = 1 and in_valid[0] = 1 with 0x55 -> beat accepted, fill_level stays 16, drop_count unchanged, and 0x55 emerges last.
- Pointer wrap: 40 continuous pushes with out_ready toggling every other cycle -> output sequence matches input sequence, fill_level never exceeds 16, and no drops while fill_level < 16.
- Drop counter edge cases: with DROP_CNT_WIDTH = 4, force 20 drops -> count holds at 15. Assert drop_clear together with a drop -> count = 1. Assert reset while FIFOs are holding data -> next cycle all out_valid = 0 and fill_level = 0.
